// File: rtl/tcb_arb_rr.sv
// Round-robin arbiter sharing one TCB subordinate between MN managers.
// Combinational grant, registered priority pointer/hold, DLY-deep response routing.
module tcb_arb_rr #(
  parameter int MN  = 4,
  parameter int ABW = 32,
  parameter int DBW = 32,
  parameter int SLW = 8,
  parameter int DLY = 1,
  localparam int BEW = DBW/SLW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MN-1:0]     man_vld,
  input  logic [MN-1:0]     man_wen,
  input  logic [MN*ABW-1:0] man_adr,
  input  logic [MN*BEW-1:0] man_ben,
  input  logic [MN*DBW-1:0] man_wdt,
  output logic [MN-1:0]     man_rdy,
  output logic [MN*DBW-1:0] man_rdt,
  output logic [MN-1:0]     man_err,
  output logic              sub_vld,
  output logic              sub_wen,
  output logic [ABW-1:0]    sub_adr,
  output logic [BEW-1:0]    sub_ben,
  output logic [DBW-1:0]    sub_wdt,
  input  logic              sub_rdy,
  input  logic [DBW-1:0]    sub_rdt,
  input  logic              sub_err
);

  localparam int PW = (MN > 1) ? $clog2(MN) : 1;

  logic [PW-1:0] r_ptr;
  logic          r_hld;
  logic [PW-1:0] r_hix;

  logic [PW-1:0] w_gnt;
  logic [PW-1:0] w_cand;
  logic          w_any;
  logic          w_vld;
  logic          w_xfer;

  assign w_any  = |man_vld;
  assign w_vld  = w_any & rst_n;
  assign w_xfer = w_vld & sub_rdy;

  // Downward search so the last hit is the first valid port at or after r_ptr.
  always_comb begin
    w_gnt  = r_ptr;
    w_cand = r_ptr;
    if (r_hld && man_vld[r_hix]) begin
      w_gnt = r_hix;
    end else begin
      for (int k = MN-1; k >= 0; k--) begin
        w_cand = PW'((int'(r_ptr) + k) % MN);
        if (man_vld[w_cand]) w_gnt = w_cand;
      end
    end
  end

  always_comb begin
    sub_vld = w_vld;
    sub_wen = 1'b0;
    sub_adr = '0;
    sub_ben = '0;
    sub_wdt = '0;
    man_rdy = '0;
    if (w_vld) begin
      sub_wen = man_wen[w_gnt];
      sub_adr = man_adr[w_gnt*ABW +: ABW];
      sub_ben = man_ben[w_gnt*BEW +: BEW];
      sub_wdt = man_wdt[w_gnt*DBW +: DBW];
    end
    if (w_xfer) man_rdy[w_gnt] = 1'b1;
  end

  assign man_rdt = {MN{sub_rdt}};

  // Hold is re-derived every cycle: a stall latches the current grant, anything else releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_hld <= 1'b0;
      r_hix <= '0;
    end else begin
      if (w_xfer) r_ptr <= PW'((int'(w_gnt) + 1) % MN);
      r_hld <= w_vld & ~sub_rdy;
      if (w_vld && !sub_rdy) r_hix <= w_gnt;
    end
  end

  generate
    if (DLY > 0) begin : g_pipe
      logic [DLY-1:0] r_pv;
      logic [PW-1:0]  r_pix [DLY];

      // Response pipeline stage 0 .. DLY-1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pv <= '0;
        end else begin
          r_pv[0] <= w_xfer;
          for (int s = 1; s < DLY; s++) r_pv[s] <= r_pv[s-1];
        end
      end

      always_ff @(posedge clk) begin
        r_pix[0] <= w_gnt;
        for (int s = 1; s < DLY; s++) r_pix[s] <= r_pix[s-1];
      end

      always_comb begin
        man_err = '0;
        if (sub_err && r_pv[DLY-1]) man_err[r_pix[DLY-1]] = 1'b1;
      end
    end else begin : g_comb
      always_comb begin
        man_err = '0;
        if (sub_err && w_xfer) man_err[w_gnt] = 1'b1;
      end
    end
  endgenerate

endmodule

// File: tb/tb_tcb_arb_rr.sv
// Bench for tcb_arb_rr: DLY=2 and DLY=0 instances on shared inputs, checked against
// a transaction-level model (pointer/hold state plus a queue of due responses).
module tb_tcb_arb_rr;
  localparam int MN = 4, ABW = 32, DBW = 32, SLW = 8, BEW = DBW/SLW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [MN-1:0]     man_vld, man_wen;
  logic [MN*ABW-1:0] man_adr;
  logic [MN*BEW-1:0] man_ben;
  logic [MN*DBW-1:0] man_wdt;
  logic              sub_rdy, sub_err;
  logic [DBW-1:0]    sub_rdt;

  logic [MN-1:0]     a_rdy, a_err, b_rdy, b_err;
  logic [MN*DBW-1:0] a_rdt, b_rdt;
  logic              a_vld, a_wen, b_vld, b_wen;
  logic [ABW-1:0]    a_adr, b_adr;
  logic [BEW-1:0]    a_ben, b_ben;
  logic [DBW-1:0]    a_wdt, b_wdt;

  tcb_arb_rr #(.MN(MN), .ABW(ABW), .DBW(DBW), .SLW(SLW), .DLY(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr),
    .man_ben(man_ben), .man_wdt(man_wdt), .man_rdy(a_rdy), .man_rdt(a_rdt), .man_err(a_err),
    .sub_vld(a_vld), .sub_wen(a_wen), .sub_adr(a_adr), .sub_ben(a_ben), .sub_wdt(a_wdt),
    .sub_rdy(sub_rdy), .sub_rdt(sub_rdt), .sub_err(sub_err));

  tcb_arb_rr #(.MN(MN), .ABW(ABW), .DBW(DBW), .SLW(SLW), .DLY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr),
    .man_ben(man_ben), .man_wdt(man_wdt), .man_rdy(b_rdy), .man_rdt(b_rdt), .man_err(b_err),
    .sub_vld(b_vld), .sub_wen(b_wen), .sub_adr(b_adr), .sub_ben(b_ben), .sub_wdt(b_wdt),
    .sub_rdy(sub_rdy), .sub_rdt(sub_rdt), .sub_err(sub_err));

  typedef struct { int due; int idx; } resp_t;
  resp_t q[$];
  int m_ptr = 0, m_hix = 0, cyc = 0;
  bit m_hld = 1'b0;
  int n_cmp = 0, n_mis = 0;

  bit          d_en = 1'b0;
  logic [3:0]  d_rdy, d_err2, d_err0;
  logic [31:0] d_adr;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int model_gnt();
    if (m_hld && man_vld[m_hix]) return m_hix;
    for (int k = 0; k < MN; k++)
      if (man_vld[(m_ptr + k) % MN]) return (m_ptr + k) % MN;
    return 0;
  endfunction

  task automatic step();
    int g;
    logic any, x;
    logic [MN-1:0] erdy, eerr2, eerr0;
    logic [95:0] ereq;
    @(negedge clk);
    g    = model_gnt();
    any  = (|man_vld) && rst_n;
    x    = any && sub_rdy;
    erdy = x ? (MN'(1) << g) : '0;
    ereq = any ? {man_wen[g], man_adr[g*ABW +: ABW], man_ben[g*BEW +: BEW], man_wdt[g*DBW +: DBW]} : '0;
    eerr2 = '0;
    if (rst_n && sub_err && q.size() > 0 && q[0].due == cyc) eerr2[q[0].idx] = 1'b1;
    eerr0 = '0;
    if (sub_err && x) eerr0[g] = 1'b1;
    chk("vld2", a_vld, any);
    chk("vld0", b_vld, any);
    chk("rdy2", a_rdy, erdy);
    chk("rdy0", b_rdy, erdy);
    chk("req2", {a_wen, a_adr, a_ben, a_wdt}, ereq);
    chk("req0", {b_wen, b_adr, b_ben, b_wdt}, ereq);
    chk("err2", a_err, eerr2);
    chk("err0", b_err, eerr0);
    chk("rdt", a_rdt, {MN{sub_rdt}});
    if (d_en) begin
      chk("dir_rdy", a_rdy, d_rdy);
      chk("dir_adr", a_adr, d_adr);
      chk("dir_err2", a_err, d_err2);
      chk("dir_err0", b_err, d_err0);
      d_en = 1'b0;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_hld = 1'b0; m_hix = 0; q.delete();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (x) begin
        q.push_back('{cyc + 2, g});
        m_ptr = (g + 1) % MN;
      end
      m_hld = any && !sub_rdy;
      if (m_hld) m_hix = g;
    end
    cyc++;
    #1;
  endtask

  // Directed cycle with fixed per-port fields: port i address is 0x1000*(i+1).
  task automatic dir(input logic [3:0] vld, input bit rdy, input bit err, input bit rn,
                     input logic [3:0] e_rdy, input logic [31:0] e_adr,
                     input logic [3:0] e_err2, input logic [3:0] e_err0);
    for (int i = 0; i < MN; i++) begin
      man_adr[i*ABW +: ABW] = 32'h1000 * (i + 1);
      man_wdt[i*DBW +: DBW] = 32'hDA7A_0000 + i;
      man_ben[i*BEW +: BEW] = BEW'(i + 1);
    end
    man_wen = 4'b0101;
    man_vld = vld; sub_rdy = rdy; sub_err = err; rst_n = rn;
    sub_rdt = 32'hCAFE_0000 + cyc;
    d_en = 1'b1; d_rdy = e_rdy; d_adr = e_adr; d_err2 = e_err2; d_err0 = e_err0;
    step();
  endtask

  initial begin
    #1;
    // Reset with every manager requesting
    for (int i = 0; i < 3; i++) dir(4'b1111, 1, 0, 0, 4'b0000, 32'h0, 4'b0, 4'b0);
    // Release: round robin 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++)
      dir(4'b1111, 1, 0, 1, 4'(1 << (k % 4)), 32'h1000 * ((k % 4) + 1), 4'b0, 4'b0);
    // Stall on port 2, port 0 appears mid-stall
    dir(4'b0100, 0, 0, 1, 4'b0000, 32'h3000, 4'b0, 4'b0);
    dir(4'b0101, 0, 0, 1, 4'b0000, 32'h3000, 4'b0, 4'b0);
    dir(4'b0101, 0, 0, 1, 4'b0000, 32'h3000, 4'b0, 4'b0);
    dir(4'b0101, 1, 0, 1, 4'b0100, 32'h3000, 4'b0, 4'b0);
    dir(4'b0101, 1, 0, 1, 4'b0001, 32'h1000, 4'b0, 4'b0);
    // Response routing: ports 1 then 3 back to back, errors return two cycles later
    dir(4'b0010, 1, 0, 1, 4'b0010, 32'h2000, 4'b0, 4'b0);
    dir(4'b1000, 1, 0, 1, 4'b1000, 32'h4000, 4'b0, 4'b0);
    dir(4'b0000, 1, 1, 1, 4'b0000, 32'h0, 4'b0010, 4'b0);
    dir(4'b0000, 1, 1, 1, 4'b0000, 32'h0, 4'b1000, 4'b0);
    dir(4'b0000, 1, 0, 1, 4'b0000, 32'h0, 4'b0, 4'b0);
    // Mid-operation reset discards the in-flight port 2 response and the pointer
    dir(4'b0100, 1, 0, 1, 4'b0100, 32'h3000, 4'b0, 4'b0);
    dir(4'b1111, 1, 0, 0, 4'b0000, 32'h0, 4'b0, 4'b0);
    dir(4'b1111, 0, 1, 1, 4'b0000, 32'h1000, 4'b0, 4'b0);
    dir(4'b1111, 1, 0, 1, 4'b0001, 32'h1000, 4'b0, 4'b0);
    dir(4'b0000, 1, 0, 1, 4'b0000, 32'h0, 4'b0, 4'b0);
    dir(4'b0000, 1, 0, 1, 4'b0000, 32'h0, 4'b0, 4'b0);
    // Zero-delay error routing, then idle bus
    dir(4'b0010, 1, 1, 1, 4'b0010, 32'h2000, 4'b0, 4'b0010);
    dir(4'b0000, 1, 0, 1, 4'b0000, 32'h0, 4'b0, 4'b0);
    // Randomized traffic, stalls, errors and occasional resets
    for (int n = 0; n < 600; n++) begin
      man_vld = MN'($urandom);
      man_wen = MN'($urandom);
      for (int i = 0; i < MN; i++) begin
        man_adr[i*ABW +: ABW] = $urandom;
        man_wdt[i*DBW +: DBW] = $urandom;
        man_ben[i*BEW +: BEW] = BEW'($urandom);
      end
      sub_rdy = ($urandom_range(0, 3) != 0);
      sub_err = 1'($urandom);
      sub_rdt = $urandom;
      rst_n   = ($urandom_range(0, 49) != 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/tcb_arb_rr.md
# tcb_arb_rr

Round-robin arbiter that shares one TCB subordinate port between `MN` TCB manager ports. Request selection is combinational (zero added latency). A registered priority pointer and a hold flag enforce fairness and keep a stalled request stable. A `DLY`-deep routing pipeline returns each response (`rdt`, `err`) to the manager that issued the request. It sits between CPU/DMA managers and a shared memory or peripheral subordinate.

## Interface
- `MN`, 4: number of manager ports (2..16)
- `ABW`, 32: address bus width
- `DBW`, 32: data bus width
- `SLW`, 8: selection width; byte-enable width `BEW = DBW/SLW`
- `DLY`, 1: subordinate response delay in cycles (0..8)

Ports:
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `man_vld` in MN: manager request valid
- `man_wen` in MN: manager write enable
- `man_adr` in MN*ABW: manager address, port i at `[i*ABW +: ABW]`
- `man_ben` in MN*BEW: manager byte enables
- `man_wdt` in MN*DBW: manager write data
- `man_rdy` out MN: manager ready
- `man_rdt` out MN*DBW: manager read data
- `man_err` out MN: manager error response
- `sub_vld` out 1: subordinate request valid
- `sub_wen` out 1: subordinate write enable
- `sub_adr` out ABW: subordinate address
- `sub_ben` out BEW: subordinate byte enables
- `sub_wdt` out DBW: subordinate write data
- `sub_rdy` in 1: subordinate ready
- `sub_rdt` in DBW: subordinate read data
- `sub_err` in 1: subordinate error response

## Operation
- Transfer on any port is defined as `vld & rdy` in the same cycle.
- **State:**
  - `ptr`: clog2(MN) bits, priority pointer.
  - `hld` and `hix`: hold flag and held index.
  - Routing pipeline: `DLY` stages of {`pv`, `pix`}.
- **Grant selection:**
  - If `hld=1` and `man_vld[hix]=1`, the grant is `hix`.
  - Otherwise the grant is the first `i` with `man_vld[i]=1`, searching `ptr, ptr+1, ... mod MN`.
  - `any` is the OR of `man_vld`.
- **Request mux:**
  - `sub_vld = any`.
  - `sub_wen/adr/ben/wdt` equal the granted port's fields.
  - When `any=0`, all `sub_*` request outputs are 0.
- **Ready:** `man_rdy[i] = sub_rdy & any & (grant==i)`. All other ports see 0.
- **Pointer:** on a subordinate transfer, `ptr <= (grant+1) mod MN`. Otherwise `ptr` holds.
- **Hold:**
  - `sub_vld & ~sub_rdy` sets `hld<=1` and `hix<=grant`.
  - A transfer clears `hld`.
  - If the held manager drops `vld` (a protocol violation), `hld` clears and arbitration resumes normally that same cycle.
- **Response routing, `DLY>0`:**
  - Stage 0 loads {transfer, grant}; each later stage shifts from the previous one.
  - `man_rdt[i] = sub_rdt` is broadcast to all ports.
  - `man_err[i] = sub_err & pv[DLY-1] & (pix[DLY-1]==i)`.
- **Response routing, `DLY=0`:** `man_err` is routed by the current grant, qualified by transfer.
- **Reset:**
  - `ptr=0`, `hld=0`, `hix=0`, all `pv=0`.
  - While `rst_n=0`, `sub_vld=0` and `man_rdy=0`, forced regardless of inputs.
  - `man_err=0`, and `sub_*` request fields are 0.
- **Mid-operation reset:** in-flight responses are discarded (`pv` cleared). A response arriving after reset release produces no `man_err`.

## Timing
- Request path latency is 0 cycles, combinational from `man_*`/`sub_rdy` to `sub_*`/`man_rdy`.
- Throughput is 1 transfer per cycle. Back-to-back transfers from different managers need no idle cycle.
- The response reaches the issuing manager exactly `DLY` cycles after its transfer. Overlapping responses are allowed with up to `DLY` transfers in flight.
- The pointer update takes effect in the cycle after a transfer.
- With all `MN` managers continuously valid and `sub_rdy=1`, grants rotate 0,1,...,MN-1, and each manager waits at most `MN-1` transfers.
- A stall (`sub_rdy=0`) never changes the grant, even if a higher-priority `vld` appears.
- The design is single-clock with no combinational loop between `sub_rdy` and `sub_vld`. `sub_vld` must not depend on `sub_rdy`.

## Test plan
- **Reset:** hold `rst_n=0` with all `man_vld=1`.
  - Required: `sub_vld=0` and `man_rdy=0000`.
  - After release: first grant is port 0, and `ptr=1` after that transfer.
- **Round-robin:** MN=4, all `vld=1`, `sub_rdy=1` for 8 cycles. Required grant sequence is 0,1,2,3,0,1,2,3.
- **Stall hold:**
  - Cycle 0: port 2 valid and granted, `sub_rdy=0` for 3 cycles; port 0 asserts `vld` in cycle 1.
  - Required: grant stays 2 until `sub_rdy=1`, with port 2 transferring in cycle 3.
  - Cycle 4: port 0 is granted, since `ptr=3` wraps to 0.
- **Response routing:** DLY=2; back-to-back transfers from ports 1 then 3, with `sub_err=1` returned at both response cycles.
  - Required: `man_err[1]=1` two cycles after its transfer and `man_err[3]=1` one cycle later.
  - No other port sees `err`.
- **Mid-operation reset:** DLY=2; transfer from port 2, then assert `rst_n=0` for 1 cycle, then `sub_err=1` at the original response cycle.
  - Required: `man_err=0000`, `ptr=0`, `hld=0`.
- **DLY=0 and idle:** DLY=0 with port 1 valid and `sub_err=1` the same cycle.
  - Required: `man_err[1]=1` in that cycle.
  - With all `vld=0`: `sub_vld=0` and `sub_adr=0`.
